// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the 8-bit CPU family.
// Drives PC, address mux, ALU, register file and zero-flag enables from the
// instruction register, with a req/ready memory handshake and a saturating
// retired-instruction counter.
// Optional feature macro: SEQ_RESUME_EN (resume input leaves HALT).
//
// state     | meaning
// FETCH     | request instruction at PC, load IR and bump PC on mem_ready
// DECODE    | select execute path from opcode
// EXECUTE   | ALU op or PC redirect
// MEMORY    | data access at PC+imm, wait for mem_ready
// WRITEBACK | register file write from ALU or memory
// HALT      | stopped until reset (or resume when enabled)
module cpu_sequencer #(
  parameter int REG_SEL_W = 1,
  parameter int OFF_W     = 3,
  parameter int CNT_W     = 16,
  localparam int INSTR_W  = 3 + 2*REG_SEL_W + OFF_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 zf,
  input  logic                 mem_ready,
  input  logic                 resume,
  output logic [2:0]           state,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic [OFF_W-1:0]     addr_offset,
  output logic [REG_SEL_W-1:0] mem_src,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic [REG_SEL_W-1:0] jmp_reg,
  output logic [OFF_W-1:0]     pc_offset,
  output logic                 ir_we,
  output logic                 alu_we,
  output logic                 zf_we,
  output logic [2:0]           alu_opcode,
  output logic [REG_SEL_W-1:0] alu_src_a,
  output logic [REG_SEL_W-1:0] alu_src_b,
  output logic                 rf_we,
  output logic [REG_SEL_W-1:0] rf_waddr,
  output logic                 rf_wsel,
  output logic                 halt,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_NOT   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_JUMP  = 3'b101;
  localparam logic [2:0] OP_JUMPZ = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t                 state_q;
  state_t                 state_d;
  logic                   retire;
  logic [2:0]             op;
  logic [REG_SEL_W-1:0]   rd;
  logic [REG_SEL_W-1:0]   rs;
  logic [OFF_W-1:0]       imm;

  assign op  = instr[INSTR_W-1 -: 3];
  assign rd  = instr[OFF_W+2*REG_SEL_W-1 -: REG_SEL_W];
  assign rs  = instr[OFF_W+REG_SEL_W-1 -: REG_SEL_W];
  assign imm = instr[OFF_W-1:0];

  assign state = state_q;

`ifdef SEQ_RESUME_EN
`else
  logic unused_resume;
  assign unused_resume = resume;
`endif

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired counter: counts completions back into FETCH, holds at all-ones.
  always_ff @(posedge clk) begin
    if (reset)                         retired <= '0;
    else if (retire && retired != '1)  retired <= retired + CNT_W'(1);
  end

  // Next-state and control outputs; everything held low while in reset.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    addr_offset = '0;
    mem_src     = '0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    jmp_reg     = '0;
    pc_offset   = '0;
    ir_we       = 1'b0;
    alu_we      = 1'b0;
    zf_we       = 1'b0;
    alu_opcode  = '0;
    alu_src_a   = '0;
    alu_src_b   = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wsel     = 1'b0;
    halt        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMORY;
            OP_HALT:           state_d = S_HALT;
            default:           state_d = S_EXECUTE;
          endcase
        end
        S_EXECUTE: begin
          state_d = S_FETCH;
          case (op)
            OP_ADD, OP_AND: begin
              alu_opcode = op;
              alu_src_a  = rd;
              alu_src_b  = rs;
              alu_we     = 1'b1;
              zf_we      = 1'b1;
              state_d    = S_WRITEBACK;
            end
            OP_NOT: begin
              // the ALU still needs its opcode to perform the inversion
              alu_opcode = op;
              alu_src_a  = rs;
              alu_we     = 1'b1;
              zf_we      = 1'b1;
              state_d    = S_WRITEBACK;
            end
            OP_JUMP, OP_JUMPZ: begin
              if (op == OP_JUMP || zf) begin
                pc_sel    = 1'b1;
                pc_we     = 1'b1;
                jmp_reg   = rd;
                pc_offset = imm;
              end
            end
            default: ;
          endcase
        end
        S_MEMORY: begin
          mem_req     = 1'b1;
          addr_sel    = 1'b1;
          addr_offset = imm;
          if (op == OP_STORE) begin
            mem_we  = 1'b1;
            mem_src = rd;
          end
          if (mem_ready) state_d = (op == OP_STORE) ? S_FETCH : S_WRITEBACK;
        end
        S_WRITEBACK: begin
          rf_we    = 1'b1;
          rf_waddr = rd;
          rf_wsel  = (op != OP_LOAD);
          state_d  = S_FETCH;
        end
        S_HALT: begin
          halt = 1'b1;
`ifdef SEQ_RESUME_EN
          if (resume) state_d = S_FETCH;
`else
`endif
        end
        default: state_d = S_FETCH;
      endcase
      retire = (state_d == S_FETCH) &&
               (state_q == S_EXECUTE || state_q == S_MEMORY || state_q == S_WRITEBACK);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: per-cycle vector table with a scoreboard queue
// of expected outputs, plus hand-written reset and halt/resume sequences.
module tb_cpu_sequencer;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic [2:0] addr_offset;
    logic       mem_src;
    logic       pc_we;
    logic       pc_sel;
    logic       jmp_reg;
    logic [2:0] pc_offset;
    logic       ir_we;
    logic       alu_we;
    logic       zf_we;
    logic [2:0] alu_opcode;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       rf_we;
    logic       rf_waddr;
    logic       rf_wsel;
    logic       halt;
    logic [1:0] retired;
  } outs_t;

  typedef struct packed {
    logic       rst;
    logic [7:0] instr;
    logic       zf;
    logic       rdy;
    logic       resume;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       zf;
  logic       mem_ready;
  logic       resume;
  logic [2:0] state;
  logic       mem_req, mem_we, addr_sel;
  logic [2:0] addr_offset;
  logic       mem_src, pc_we, pc_sel, jmp_reg;
  logic [2:0] pc_offset;
  logic       ir_we, alu_we, zf_we;
  logic [2:0] alu_opcode;
  logic       alu_src_a, alu_src_b, rf_we, rf_waddr, rf_wsel, halt;
  logic [1:0] retired;

  outs_t act;
  outs_t exp_q[$];
  vec_t  tbl[$];
  int    errors = 0;
  int    checks = 0;

  cpu_sequencer #(.REG_SEL_W(1), .OFF_W(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zf(zf), .mem_ready(mem_ready),
    .resume(resume), .state(state), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .addr_offset(addr_offset), .mem_src(mem_src),
    .pc_we(pc_we), .pc_sel(pc_sel), .jmp_reg(jmp_reg), .pc_offset(pc_offset),
    .ir_we(ir_we), .alu_we(alu_we), .zf_we(zf_we), .alu_opcode(alu_opcode),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .halt(halt), .retired(retired)
  );

  always #5 clk = ~clk;

  always_comb begin
    act             = '0;
    act.state       = state;
    act.mem_req     = mem_req;
    act.mem_we      = mem_we;
    act.addr_sel    = addr_sel;
    act.addr_offset = addr_offset;
    act.mem_src     = mem_src;
    act.pc_we       = pc_we;
    act.pc_sel      = pc_sel;
    act.jmp_reg     = jmp_reg;
    act.pc_offset   = pc_offset;
    act.ir_we       = ir_we;
    act.alu_we      = alu_we;
    act.zf_we       = zf_we;
    act.alu_opcode  = alu_opcode;
    act.alu_src_a   = alu_src_a;
    act.alu_src_b   = alu_src_b;
    act.rf_we       = rf_we;
    act.rf_waddr    = rf_waddr;
    act.rf_wsel     = rf_wsel;
    act.halt        = halt;
    act.retired     = retired;
  end

  function automatic outs_t f_rst(input logic [2:0] st, input logic [1:0] ret);
    outs_t o = '0;
    o.state = st; o.retired = ret;
    return o;
  endfunction

  function automatic outs_t f_fetch(input logic rdy, input logic [1:0] ret);
    outs_t o = '0;
    o.state = 3'd0; o.mem_req = 1'b1; o.ir_we = rdy; o.pc_we = rdy; o.retired = ret;
    return o;
  endfunction

  function automatic outs_t f_dec(input logic [1:0] ret);
    outs_t o = '0;
    o.state = 3'd1; o.retired = ret;
    return o;
  endfunction

  function automatic outs_t f_ex_alu(input logic [2:0] opc, input logic a, input logic b,
                                     input logic [1:0] ret);
    outs_t o = '0;
    o.state = 3'd2; o.alu_opcode = opc; o.alu_src_a = a; o.alu_src_b = b;
    o.alu_we = 1'b1; o.zf_we = 1'b1; o.retired = ret;
    return o;
  endfunction

  function automatic outs_t f_ex_jmp(input logic taken, input logic r, input logic [2:0] off,
                                     input logic [1:0] ret);
    outs_t o = '0;
    o.state = 3'd2; o.retired = ret;
    if (taken) begin
      o.pc_sel = 1'b1; o.pc_we = 1'b1; o.jmp_reg = r; o.pc_offset = off;
    end
    return o;
  endfunction

  function automatic outs_t f_mem(input logic we, input logic [2:0] off, input logic src,
                                  input logic [1:0] ret);
    outs_t o = '0;
    o.state = 3'd3; o.mem_req = 1'b1; o.addr_sel = 1'b1; o.addr_offset = off;
    o.mem_we = we; o.mem_src = src; o.retired = ret;
    return o;
  endfunction

  function automatic outs_t f_wb(input logic wa, input logic wsel, input logic [1:0] ret);
    outs_t o = '0;
    o.state = 3'd4; o.rf_we = 1'b1; o.rf_waddr = wa; o.rf_wsel = wsel; o.retired = ret;
    return o;
  endfunction

  function automatic outs_t f_halt(input logic [1:0] ret);
    outs_t o = '0;
    o.state = 3'd5; o.halt = 1'b1; o.retired = ret;
    return o;
  endfunction

  function automatic vec_t mk(input logic r, input logic [7:0] i, input logic z,
                              input logic rd, input logic rs, input outs_t e);
    vec_t v;
    v.rst = r; v.instr = i; v.zf = z; v.rdy = rd; v.resume = rs; v.exp = e;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, queue its expectation,
  // then compare the settled outputs before the next rising edge.
  task automatic step(input string name, input vec_t v);
    outs_t e;
    @(negedge clk);
    reset     = v.rst;
    instr     = v.instr;
    zf        = v.zf;
    mem_ready = v.rdy;
    resume    = v.resume;
    exp_q.push_back(v.exp);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
               name, act.state, act, e.state, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; instr = 8'h00; zf = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);

    // reset forcing, then ADD r1,r0
    tbl.push_back(mk(1, 8'h10, 0, 1, 0, f_rst(3'd0, 2'd0)));
    tbl.push_back(mk(0, 8'h10, 0, 1, 0, f_fetch(1, 2'd0)));
    tbl.push_back(mk(0, 8'h10, 0, 1, 0, f_dec(2'd0)));
    tbl.push_back(mk(0, 8'h10, 1, 1, 0, f_ex_alu(3'b000, 1, 0, 2'd0)));
    tbl.push_back(mk(0, 8'h10, 0, 1, 0, f_wb(1, 1, 2'd0)));
    // LOAD r0,+5 with two wait states in MEMORY
    tbl.push_back(mk(0, 8'h65, 0, 1, 0, f_fetch(1, 2'd1)));
    tbl.push_back(mk(0, 8'h65, 0, 1, 0, f_dec(2'd1)));
    tbl.push_back(mk(0, 8'h65, 0, 0, 0, f_mem(0, 3'd5, 0, 2'd1)));
    tbl.push_back(mk(0, 8'h65, 0, 0, 0, f_mem(0, 3'd5, 0, 2'd1)));
    tbl.push_back(mk(0, 8'h65, 0, 1, 0, f_mem(0, 3'd5, 0, 2'd1)));
    tbl.push_back(mk(0, 8'h65, 0, 1, 0, f_wb(0, 0, 2'd1)));
    // JUMPZ r1,+2 not taken, with one FETCH wait state
    tbl.push_back(mk(0, 8'hD2, 0, 0, 0, f_fetch(0, 2'd2)));
    tbl.push_back(mk(0, 8'hD2, 0, 1, 0, f_fetch(1, 2'd2)));
    tbl.push_back(mk(0, 8'hD2, 0, 1, 0, f_dec(2'd2)));
    tbl.push_back(mk(0, 8'hD2, 0, 1, 0, f_ex_jmp(0, 1, 3'd2, 2'd2)));
    // JUMPZ taken; mem_ready low outside FETCH/MEMORY is ignored
    tbl.push_back(mk(0, 8'hD2, 1, 1, 0, f_fetch(1, 2'd3)));
    tbl.push_back(mk(0, 8'hD2, 1, 0, 0, f_dec(2'd3)));
    tbl.push_back(mk(0, 8'hD2, 1, 0, 0, f_ex_jmp(1, 1, 3'd2, 2'd3)));
    // STORE r1,+0: counter now saturated at 3
    tbl.push_back(mk(0, 8'h90, 0, 1, 0, f_fetch(1, 2'd3)));
    tbl.push_back(mk(0, 8'h90, 0, 1, 0, f_dec(2'd3)));
    tbl.push_back(mk(0, 8'h90, 0, 1, 0, f_mem(1, 3'd0, 1, 2'd3)));
    // JUMP r1,+3 (unconditional, zf low)
    tbl.push_back(mk(0, 8'hB3, 0, 1, 0, f_fetch(1, 2'd3)));
    tbl.push_back(mk(0, 8'hB3, 0, 1, 0, f_dec(2'd3)));
    tbl.push_back(mk(0, 8'hB3, 0, 1, 0, f_ex_jmp(1, 1, 3'd3, 2'd3)));
    // AND r0,r1
    tbl.push_back(mk(0, 8'h28, 0, 1, 0, f_fetch(1, 2'd3)));
    tbl.push_back(mk(0, 8'h28, 0, 1, 0, f_dec(2'd3)));
    tbl.push_back(mk(0, 8'h28, 0, 1, 0, f_ex_alu(3'b001, 0, 1, 2'd3)));
    tbl.push_back(mk(0, 8'h28, 0, 1, 0, f_wb(0, 1, 2'd3)));
    // HALT: halt from the third cycle, stays there
    tbl.push_back(mk(0, 8'hE0, 0, 1, 0, f_fetch(1, 2'd3)));
    tbl.push_back(mk(0, 8'hE0, 0, 1, 0, f_dec(2'd3)));
    tbl.push_back(mk(0, 8'hE0, 0, 1, 0, f_halt(2'd3)));
    tbl.push_back(mk(0, 8'hE0, 0, 1, 0, f_halt(2'd3)));

    foreach (tbl[i]) step($sformatf("table_row%0d", i), tbl[i]);

    // reset while a LOAD is waiting in MEMORY
    step("rst_clear",    mk(1, 8'h65, 0, 0, 0, f_rst(3'd5, 2'd3)));
    step("rst_fetch",    mk(0, 8'h65, 0, 1, 0, f_fetch(1, 2'd0)));
    step("rst_decode",   mk(0, 8'h65, 0, 1, 0, f_dec(2'd0)));
    step("rst_mem_wait", mk(0, 8'h65, 0, 0, 0, f_mem(0, 3'd5, 0, 2'd0)));
    step("rst_in_mem",   mk(1, 8'h65, 0, 0, 0, f_rst(3'd3, 2'd0)));
    step("rst_after",    mk(0, 8'h65, 0, 0, 0, f_fetch(0, 2'd0)));

    // HALT then resume; HALT itself is not retired
    step("hr_fetch",  mk(0, 8'hE0, 0, 1, 0, f_fetch(1, 2'd0)));
    step("hr_decode", mk(0, 8'hE0, 0, 1, 0, f_dec(2'd0)));
    step("hr_halt",   mk(0, 8'hE0, 0, 1, 1, f_halt(2'd0)));
`ifdef SEQ_RESUME_EN
    step("hr_resumed", mk(0, 8'hE0, 0, 1, 0, f_fetch(1, 2'd0)));
`else
    step("hr_stays",   mk(0, 8'hE0, 0, 1, 1, f_halt(2'd0)));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
